// File: rtl/tcn_to_7seg_seq_if.sv
// Request/result bundle for the sequential 7-segment converter.
// The master issues start with N/is_signed; the slave returns busy/done and
// the registered segment patterns.
interface tcn_to_7seg_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      N;
  logic                  is_signed;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [6:0]            Sign;
  logic [7*DIGITS-1:0]   Magnitude;

  modport master (
    output start, N, is_signed,
    input  busy, done, ovf, Sign, Magnitude
  );

  modport slave (
    input  start, N, is_signed,
    output busy, done, ovf, Sign, Magnitude
  );
endinterface

// File: rtl/tcn_to_7seg_seq.sv
// Sequential WIDTH-bit to sign + DIGITS decimal 7-segment converter.
// Uses an iterative double-dabble engine (one bit per cycle) and registers
// all outputs, so there is no combinational path from inputs to outputs.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
module tcn_to_7seg_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  tcn_to_7seg_seq_if.slave bus
);

  // One spare nibble above the displayed digits catches overflow.
  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Reset display: "0" in digit 0, upper digits blank or "0" depending on blanking.
  function automatic logic [7*DIGITS-1:0] reset_magnitude();
    logic [7*DIGITS-1:0] m;
    for (int i = 0; i < DIGITS; i++)
      m[7*i +: 7] = (i == 0 || !BLANK_LZ) ? SEG_ZERO : SEG_BLANK;
    return m;
  endfunction

  localparam logic [7*DIGITS-1:0] MAG_RESET = reset_magnitude();

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_nxt;
  logic                neg;
  logic [WIDTH:0]      mag;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic                bcd_lost;
  logic [CNT_W-1:0]    cnt;
  logic                last_step;
  logic                is_neg;
  logic [WIDTH:0]      mag_abs;
  logic                ovf_nxt;
  logic [7*DIGITS-1:0] mag_nxt;
  logic                leading;

  // Sign-extend before negating so the most negative input yields +2^(WIDTH-1).
  assign is_neg    = bus.is_signed & bus.N[WIDTH-1];
  assign mag_abs   = is_neg ? -{bus.N[WIDTH-1], bus.N} : {1'b0, bus.N};
  assign last_step = (cnt == CNT_W'(WIDTH));
  assign bus.busy  = (state != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> CONV on start, CONV for WIDTH+1 steps, one DONE cycle.
  // NOTE: defaults are assigned first so no path through the block infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CONV;
      CONV:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i <= DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Capture the request in IDLE, then shift one magnitude bit into BCD per CONV cycle.
  // A 1 leaving the top of the BCD register means the value outgrew even the spare
  // nibble, so it is kept as a sticky overflow.
  // NOTE: datapath registers are not reset; each one is loaded on start before it is read.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      neg      <= is_neg;
      mag      <= mag_abs;
      bcd      <= '0;
      bcd_lost <= 1'b0;
      cnt      <= '0;
    end else if (state == CONV) begin
      bcd      <= {bcd_adj[BCD_W-2:0], mag[WIDTH]};
      bcd_lost <= bcd_lost | bcd_adj[BCD_W-1];
      mag      <= {mag[WIDTH-1:0], 1'b0};
      cnt      <= cnt + CNT_W'(1);
    end
  end

  // Format the finished BCD: dashes on overflow, otherwise digits with optional
  // leading-zero blanking scanned from the most significant digit down.
  always_comb begin
    ovf_nxt = bcd_lost | (bcd[BCD_W-1 -: 4] != 4'd0);
    mag_nxt = '0;
    leading = BLANK_LZ;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_nxt) begin
        mag_nxt[7*i +: 7] = SEG_DASH;
      end else if (leading && i != 0 && bcd[4*i +: 4] == 4'd0) begin
        mag_nxt[7*i +: 7] = SEG_BLANK;
      end else begin
        mag_nxt[7*i +: 7] = seg_of(bcd[4*i +: 4]);
        leading = 1'b0;
      end
    end
  end

  // Output registers: updated only on leaving DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.done      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.Sign      <= SEG_BLANK;
      bus.Magnitude <= MAG_RESET;
    end else begin
      bus.done <= (state == DONE);
      if (state == DONE) begin
        bus.ovf       <= ovf_nxt;
        bus.Sign      <= neg ? SEG_DASH : SEG_BLANK;
        bus.Magnitude <= mag_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tcn_to_7seg_seq.sv
// Self-checking bench for tcn_to_7seg_seq. Two instances share one stimulus
// stream: A (DIGITS=3, blanking on) and B (DIGITS=2, blanking off). A decimal
// reference model computes expected results, a posedge process queues them
// with their due cycle, and a negedge monitor compares every cycle.
module tb_tcn_to_7seg_seq;

  localparam int W = 8;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  typedef struct packed {
    logic [6:0]  sign;
    logic [20:0] mag;
    logic        ovf;
  } res_t;

  typedef struct {
    int   due;
    res_t a;
    res_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       is_signed = 1'b0;
  logic [7:0] n_in = 8'd0;

  always #5 clk = ~clk;

  tcn_to_7seg_seq_if #(.WIDTH(W), .DIGITS(3)) if_a ();
  tcn_to_7seg_seq_if #(.WIDTH(W), .DIGITS(2)) if_b ();

  assign if_a.start     = start;
  assign if_a.N         = n_in;
  assign if_a.is_signed = is_signed;
  assign if_b.start     = start;
  assign if_b.N         = n_in;
  assign if_b.is_signed = is_signed;

  tcn_to_7seg_seq #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  tcn_to_7seg_seq #(.WIDTH(W), .DIGITS(2), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   busy_lo = 0;
  int   busy_hi = -1;
  int   rst_cyc = -1;
  bit   armed = 1'b0;
  exp_t q[$];
  exp_t e;
  res_t last_a, last_b;
  logic exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: magnitude in decimal; a digit is blank when blanking is on and
  // the value is below 10^i; dashes everywhere when value >= 10^digits.
  function automatic res_t model(input logic [7:0] n, input bit s, input int digits, input bit blank);
    res_t r;
    int   v;
    int   p;
    int   lim;
    bit   neg;
    neg = s && n[7];
    v   = neg ? 256 - int'(n) : int'(n);
    lim = 1;
    for (int i = 0; i < digits; i++) lim *= 10;
    r.sign = neg ? DASH : BLANK;
    r.ovf  = (v >= lim);
    r.mag  = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      if (r.ovf)                        r.mag[7*i +: 7] = DASH;
      else if (blank && i > 0 && v < p) r.mag[7*i +: 7] = BLANK;
      else                              r.mag[7*i +: 7] = seg_tab[(v / p) % 10];
      p *= 10;
    end
    return r;
  endfunction

  // Request tracker: decides acceptance from the bench's own timing model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      armed     = 1'b1;
      rst_cyc   = cyc;
      next_free = cyc + 1;
      busy_lo   = 0;
      busy_hi   = -1;
    end else if (armed && start && cyc >= next_free) begin
      e.due = cyc + W + 2;
      e.a   = model(n_in, is_signed, 3, 1'b1);
      e.b   = model(n_in, is_signed, 2, 1'b0);
      q.push_back(e);
      next_free = cyc + W + 3;
      busy_lo   = cyc;
      busy_hi   = cyc + W + 1;
    end
  end

  // Monitor: compares handshake and held outputs of both instances each cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_cyc == cyc) begin
        last_a = model(8'd0, 1'b0, 3, 1'b1);
        last_b = model(8'd0, 1'b0, 2, 1'b0);
      end
      exp_done = (q.size() > 0 && q[0].due == cyc);
      if (exp_done) begin
        e = q.pop_front();
        last_a = e.a;
        last_b = e.b;
      end
      check("done_a", 32'(if_a.done), 32'(exp_done));
      check("done_b", 32'(if_b.done), 32'(exp_done));
      check("busy_a", 32'(if_a.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("busy_b", 32'(if_b.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("sign_a", 32'(if_a.Sign), 32'(last_a.sign));
      check("sign_b", 32'(if_b.Sign), 32'(last_b.sign));
      check("mag_a",  32'(if_a.Magnitude), 32'(last_a.mag[20:0]));
      check("mag_b",  32'(if_b.Magnitude), 32'(last_b.mag[13:0]));
      check("ovf_a",  32'(if_a.ovf), 32'(last_a.ovf));
      check("ovf_b",  32'(if_b.ovf), 32'(last_b.ovf));
    end
  end

  task automatic pulse(input logic [7:0] n, input bit s);
    @(negedge clk);
    start = 1'b1; n_in = n; is_signed = s;
    @(negedge clk);
    start = 1'b0; n_in = 8'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] dir_n [12] = '{8'h80, 8'hFF, 8'hFF, 8'd100, 8'd99, 8'd0,
                             8'd0, 8'h7F, 8'h01, 8'd7, 8'd10, 8'hF6};
  bit         dir_s [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int r;
    // Power-on reset for two cycles.
    idle(2);
    @(negedge clk) reset = 1'b0;
    idle(2);

    // Directed values, one conversion at a time.
    for (int i = 0; i < 12; i++) begin
      pulse(dir_n[i], dir_s[i]);
      idle(W + 3);
    end

    // start held high: restart lands on the first cycle busy is low.
    @(negedge clk);
    start = 1'b1; n_in = 8'd42; is_signed = 1'b0;
    idle(19);
    start = 1'b0;
    idle(W + 4);

    // Extra start in the middle of a conversion is dropped.
    pulse(8'h55, 1'b0);
    idle(3);
    pulse(8'h12, 1'b1);
    idle(W + 4);

    // Reset four cycles after start, then a fresh conversion.
    pulse(8'd200, 1'b0);
    idle(2);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    idle(1);
    pulse(8'd7, 1'b0);
    idle(W + 4);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      reset     = (r < 2);
      start     = (r >= 2 && r < 45);
      n_in      = (r % 4 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      is_signed = 1'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    idle(W + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcn_to_7seg_seq.md
# tcn_to_7seg_seq

Sequential, parametrised successor to the 4-bit two's-complement 7-segment decoder. It converts a WIDTH-bit value to a sign digit plus DIGITS decimal magnitude digits using an iterative double-dabble engine. Signed or unsigned interpretation is selectable per request, with optional leading-zero blanking and an overflow indication. It sits between datapath registers and the board HEX displays, and all segment outputs are active-low.

## Interface
- WIDTH, 8: input value width, 2..32.
- DIGITS, 3: number of magnitude digits driven, 1..10.
- BLANK_LZ, 1: 1 blanks leading zero digits. The least-significant digit is never blanked.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- N  in  WIDTH  value to display; sampled with start.
- is_signed  in  1  1 = two's complement, 0 = unsigned; sampled with start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when outputs update.
- ovf  out  1  magnitude ≥ 10^DIGITS for the last result.
- Sign  out  7  sign digit: 7'b0111111 if negative, else 7'b1111111.
- Magnitude  out  7*DIGITS  digit i occupies [7i+6:7i]; digit 0 is the least significant.

## Operation
- Segment encoding uses bit order {g,f,e,d,c,b,a} and is active-low.
- Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank=1111111. Dash=0111111.
- FSM states: IDLE, CONV, DONE.
- IDLE, start=1:
  - latch neg = is_signed & N[WIDTH-1];
  - latch mag = neg ? -N : N, computed WIDTH+1 bits wide so that -2^(WIDTH-1) yields +2^(WIDTH-1);
  - clear the BCD shift register (4*(DIGITS+1) bits; the extra nibble detects overflow);
  - clear the bit counter; go to CONV.
- IDLE, start=0: remain in IDLE.
- CONV, one step per cycle: add 3 to every BCD nibble ≥ 5, then shift left one bit, taking the MSB of mag.
  - After WIDTH+1 steps (all magnitude bits consumed), go to DONE.
- DONE, single cycle:
  - register Sign, Magnitude and ovf; assert done; go to IDLE.
  - ovf=1 when any bit above the low 4*DIGITS BCD bits is nonzero. In that case every Magnitude digit shows dash.
  - With BLANK_LZ=1, digits above the most significant nonzero digit show blank. Digit 0 always shows its value.
  - Sign reflects neg. Unsigned mode never shows a negative sign.
- start while busy is ignored, with no queueing. Inputs N and is_signed are don't-care outside IDLE.
- Sign, Magnitude and ovf hold their last result until the next DONE.
- Reset, at any time including mid-CONV:
  - state goes to IDLE; busy=0, done=0, ovf=0;
  - Sign=1111111;
  - Magnitude shows "0" in digit 0. Other digits show blank if BLANK_LZ=1, else "0".

## Timing
- start is sampled high at edge k. busy goes high after edge k.
- CONV occupies edges k+1 .. k+WIDTH+1.
- DONE is entered after edge k+WIDTH+1. Outputs update and done=1 after edge k+WIDTH+2.
- Latency is WIDTH+2 cycles from the start edge to done.
- busy is high from after edge k through the DONE cycle, and low after done drops.
- done is exactly one cycle wide.
- start asserted during the DONE cycle is ignored. The earliest accepted restart is the first cycle with busy=0.
- Throughput is one conversion per WIDTH+3 cycles.
- No combinational path from any input to any output.

## Test plan
- Reset check (WIDTH=8, DIGITS=3, BLANK_LZ=1): assert reset for 2 cycles → Sign=1111111, Magnitude={1111111,1111111,1000000}, busy=0, done=0, ovf=0.
- Most-negative value: start, N=8'h80, is_signed=1 → done exactly 10 cycles after the start edge; Sign=0111111; digits 1,2,8 = {1111001,0100100,0000000}; ovf=0.
- Same input, two interpretations:
  - N=8'hFF, is_signed=0 → Sign blank, digits 2,5,5.
  - N=8'hFF, is_signed=1 → Sign=0111111, digits blank,blank,1.
- Overflow (DIGITS=2): N=8'd100, is_signed=0 → ovf=1, both digits 0111111. A following N=8'd99 → ovf=0, digits 9,9.
- Handshake:
  - start held high for 20 cycles with N=8'd42 → first conversion completes; start in DONE cycle is ignored; second accepted on first busy=0 cycle; each done is a one-cycle pulse.
  - start pulsed mid-CONV → no extra done.
- Reset mid-conversion: assert reset 4 cycles after start with N=8'd200 → next cycle busy=0, outputs equal reset values, no done pulse. A new start with N=8'd7 → digits blank,blank,7.
